uart_tx_fifo: RTL and testbench

//  Transmit half of the FPGC4 UART; drives the top-level uart_out pin.

---
 rtl/uart_tx_fifo_pkg.sv | 17 +
 rtl/uart_tx_fifo_fifo.sv | 58 +++++
 rtl/uart_tx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: transmit FSM encodings, frame length and the baud divisor helper.
// The receive path uses the same divisor helper, so both directions agree on bit timing.
package uart_tx_fifo_pkg;

    localparam logic [1:0] UTX_IDLE  = 2'd0;
    localparam logic [1:0] UTX_START = 2'd1;
    localparam logic [1:0] UTX_DATA  = 2'd2;
    localparam logic [1:0] UTX_STOP  = 2'd3;

    localparam int UART_FRAME_BITS = 10;

    // Clock cycles per bit; the fractional part of the ratio is dropped.
    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// Synchronous byte FIFO with occupancy count; the head entry is visible on dout whenever count > 0.
// Pushes while full and pops while empty are ignored.
module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: queued bytes are sent as 8N1 frames on a registered line output.
// A one-cycle interrupt marks the end of the last frame once the queue has drained.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_busy,
    output logic                          tx_done_interrupt,
    output logic                          uart_out
);

    localparam int DIV = uart_div(CLK_HZ, BAUD);
    localparam int BW  = $clog2(DIV);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          out_q, out_d;
    logic          irq_q, irq_d;
    logic          busy_q, busy_d;

    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic          push_acc;
    logic          bit_end;
    logic [CW-1:0] count_nxt;

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (wr_en),
        .din    (wr_data),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign push_acc = wr_en & ~fifo_full;
    assign bit_end  = (baud_q == BW'(DIV - 1));

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + BW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        out_d    = out_q;
        irq_d    = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            UTX_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = UTX_START;
                    out_d    = 1'b0;
                end
            end
            UTX_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = UTX_DATA;
                    out_d   = shift_q[0];
                end
            end
            UTX_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = UTX_STOP;
                        out_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        out_d   = shift_q[1];
                    end
                end
            end
            default: begin
                // Chaining straight into the next start bit keeps the frame period at 10*DIV.
                if (bit_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = UTX_START;
                        out_d    = 1'b0;
                    end else begin
                        state_d = UTX_IDLE;
                        irq_d   = 1'b1;
                    end
                end
            end
        endcase
    end

    assign count_nxt = fifo_count + CW'(push_acc) - CW'(fifo_pop);
    assign busy_d    = (state_d != UTX_IDLE) | (count_nxt != '0);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= UTX_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            out_q   <= 1'b1;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            out_q   <= out_d;
            irq_q   <= irq_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign uart_out          = out_q;
    assign tx_done_interrupt = irq_q;
    assign tx_busy           = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: scenario tasks plus a frame-timeline reference model and a line decoder.
module tb_uart_tx_fifo;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int FRAME  = 10 * DIV;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          tx_busy;
    logic          tx_done_interrupt;
    logic          uart_out;

    int checks = 0;
    int errors = 0;
    int irq_seen = 0;

    uart_tx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .nreset            (nreset),
        .wr_en             (wr_en),
        .wr_data           (wr_data),
        .fifo_full         (fifo_full),
        .fifo_count        (fifo_count),
        .tx_busy           (tx_busy),
        .tx_done_interrupt (tx_done_interrupt),
        .uart_out          (uart_out)
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue plus the position inside the frame on the wire (-1 = idle line).
    logic [7:0] m_q[$];
    logic [7:0] m_acc[$];
    logic [7:0] m_cur = 8'h00;
    int         m_ft = -1;
    bit         m_irq = 1'b0;
    bit         m_valid = 1'b0;
    bit         m_full;

    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        int k;
        k = pos / DIV;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    function automatic logic exp_line();
        if (m_ft < 0) return 1'b1;
        return frame_bit(m_cur, m_ft);
    endfunction

    always @(posedge clk) begin
        if (!nreset) begin
            m_q.delete();
            m_ft    = -1;
            m_irq   = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_full = (m_q.size() == DEPTH);
            m_irq  = 1'b0;
            if (m_ft < 0 || m_ft == FRAME - 1) begin
                if (m_q.size() != 0) begin
                    m_cur = m_q.pop_front();
                    m_ft  = 0;
                end else if (m_ft == FRAME - 1) begin
                    m_ft  = -1;
                    m_irq = 1'b1;
                end
            end else begin
                m_ft++;
            end
            if (wr_en && !m_full) begin
                m_q.push_back(wr_data);
                m_acc.push_back(wr_data);
            end
        end
    end

    // Lockstep comparison against the model plus an independent mid-bit line decoder.
    logic [7:0] rx[$];
    logic       prev_line = 1'b1;
    bit         dec_on = 1'b0;
    int         dec_c = 0;
    logic [7:0] dec_byte = 8'h00;

    always @(negedge clk) begin
        if (m_valid) begin
            checks += 5;
            if (uart_out !== exp_line()) begin
                errors++;
                $display("FAIL line @%0t: got %b expected %b", $time, uart_out, exp_line());
            end
            if (fifo_count !== CW'(m_q.size())) begin
                errors++;
                $display("FAIL count @%0t: got %0d expected %0d", $time, fifo_count, m_q.size());
            end
            if (fifo_full !== (m_q.size() == DEPTH)) begin
                errors++;
                $display("FAIL full @%0t: got %b expected %b", $time, fifo_full, m_q.size() == DEPTH);
            end
            if (tx_busy !== (m_ft >= 0 || m_q.size() != 0)) begin
                errors++;
                $display("FAIL busy @%0t: got %b expected %b", $time, tx_busy, (m_ft >= 0 || m_q.size() != 0));
            end
            if (tx_done_interrupt !== m_irq) begin
                errors++;
                $display("FAIL irq @%0t: got %b expected %b", $time, tx_done_interrupt, m_irq);
            end
        end
        if (tx_done_interrupt === 1'b1) irq_seen++;
        if (!nreset) begin
            dec_on = 1'b0;
        end else if (!dec_on) begin
            if (prev_line === 1'b1 && uart_out === 1'b0) begin
                dec_on = 1'b1;
                dec_c  = 0;
            end
        end else begin
            dec_c++;
            if (dec_c % DIV == DIV / 2) begin
                if (dec_c / DIV >= 1 && dec_c / DIV <= 8) dec_byte[dec_c/DIV-1] = uart_out;
                if (dec_c / DIV == 9) begin
                    rx.push_back(dec_byte);
                    dec_on = 1'b0;
                end
            end
        end
        prev_line = uart_out;
    end

    task automatic do_reset();
        nreset = 1'b0;
        wr_en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        rx.delete();
        m_acc.delete();
    endtask

    task automatic wait_idle(input int limit, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (tx_busy === 1'b0 && m_ft < 0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        wr_en  = 1'b1;
        wr_data = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (uart_out !== 1'b1) begin errors++; $display("FAIL reset_line: got %b expected 1", uart_out); end
        if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        if (tx_done_interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", tx_done_interrupt); end
        wr_en  = 1'b0;
        nreset = 1'b1;
    endtask

    task automatic test_single_frame();
        int irq0;
        do_reset();
        irq0 = irq_seen;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        @(posedge clk); #1;
        wr_en = 1'b0;
        checks += 2;
        if (fifo_count !== CW'(1)) begin errors++; $display("FAIL t1_count_after_push: got %0d expected 1", fifo_count); end
        if (uart_out !== 1'b1) begin errors++; $display("FAIL t1_line_after_push: got %b expected 1", uart_out); end
        @(posedge clk); #1;
        for (int c = 0; c < FRAME; c++) begin
            checks += 2;
            if (uart_out !== frame_bit(8'hA5, c)) begin
                errors++; $display("FAIL t1_bit c=%0d: got %b expected %b", c, uart_out, frame_bit(8'hA5, c));
            end
            if (tx_done_interrupt !== 1'b0) begin errors++; $display("FAIL t1_early_irq c=%0d: got 1 expected 0", c); end
            @(posedge clk); #1;
        end
        checks += 2;
        if (tx_done_interrupt !== 1'b1) begin errors++; $display("FAIL t1_irq: got %b expected 1", tx_done_interrupt); end
        if (uart_out !== 1'b1) begin errors++; $display("FAIL t1_idle_line: got %b expected 1", uart_out); end
        @(posedge clk); #1;
        checks += 2;
        if (tx_done_interrupt !== 1'b0) begin errors++; $display("FAIL t1_irq_width: got %b expected 0", tx_done_interrupt); end
        if (irq_seen - irq0 != 1) begin errors++; $display("FAIL t1_irq_count: got %0d expected 1", irq_seen - irq0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int irq0;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
        do_reset();
        irq0 = irq_seen;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = bytes[i];
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        // Now just after the third push edge, which is cycle 1 of the frame train.
        for (int c = 1; c < 3 * FRAME; c++) begin
            checks += 3;
            if (uart_out !== frame_bit(bytes[c/FRAME], c % FRAME)) begin
                errors++; $display("FAIL t2_bit c=%0d: got %b expected %b", c, uart_out, frame_bit(bytes[c/FRAME], c % FRAME));
            end
            if (tx_busy !== 1'b1) begin errors++; $display("FAIL t2_busy c=%0d: got %b expected 1", c, tx_busy); end
            if (tx_done_interrupt !== 1'b0) begin errors++; $display("FAIL t2_early_irq c=%0d: got 1 expected 0", c); end
            @(posedge clk); #1;
        end
        checks += 2;
        if (tx_done_interrupt !== 1'b1) begin errors++; $display("FAIL t2_irq: got %b expected 1", tx_done_interrupt); end
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL t2_busy_end: got %b expected 0", tx_busy); end
        repeat (5) @(posedge clk);
        #1;
        checks += 2;
        if (irq_seen - irq0 != 1) begin errors++; $display("FAIL t2_irq_count: got %0d expected 1", irq_seen - irq0); end
        if (rx.size() != 3) begin
            errors++; $display("FAIL t2_rx_size: got %0d expected 3", rx.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx[i] !== bytes[i]) begin errors++; $display("FAIL t2_rx[%0d]: got %h expected %h", i, rx[i], bytes[i]); end
            end
        end
    endtask

    task automatic fill_fifo(input bit low_half);
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = low_half ? 8'($urandom_range(0, 127)) : 8'($urandom);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic check_rx_vs_model(input string tag);
        checks++;
        if (rx.size() != m_acc.size()) begin
            errors++; $display("FAIL %s_rx_size: got %0d expected %0d", tag, rx.size(), m_acc.size());
        end else begin
            for (int i = 0; i < rx.size(); i++) begin
                checks++;
                if (rx[i] !== m_acc[i]) begin errors++; $display("FAIL %s_rx[%0d]: got %h expected %h", tag, i, rx[i], m_acc[i]); end
            end
        end
    endtask

    task automatic test_overflow();
        int peak;
        bit saw_full;
        bit to;
        do_reset();
        peak = 0;
        saw_full = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 8'($urandom);
            @(posedge clk); #1;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (fifo_full === 1'b1) saw_full = 1'b1;
        end
        wr_en = 1'b0;
        checks += 2;
        if (peak != DEPTH) begin errors++; $display("FAIL t3_peak: got %0d expected %0d", peak, DEPTH); end
        if (!saw_full) begin errors++; $display("FAIL t3_full_seen: got 0 expected 1"); end
        wait_idle(20 * FRAME, to);
        checks += 2;
        if (to) begin errors++; $display("FAIL t3_drain_timeout: busy=%b expected 0", tx_busy); end
        if (rx.size() != 17) begin errors++; $display("FAIL t3_rx_total: got %0d expected 17", rx.size()); end
        check_rx_vs_model("t3");
    endtask

    task automatic test_push_while_full();
        logic [7:0] extra;
        int hits;
        bit to;
        do_reset();
        fill_fifo(1'b1);
        extra = 8'h80 | 8'($urandom_range(0, 127));
        wr_en = 1'b1;
        wr_data = extra;
        @(posedge clk); #1;
        wr_en = 1'b0;
        checks += 2;
        if (fifo_count !== CW'(DEPTH)) begin errors++; $display("FAIL t4_count: got %0d expected %0d", fifo_count, DEPTH); end
        if (fifo_full !== 1'b1) begin errors++; $display("FAIL t4_full: got %b expected 1", fifo_full); end
        wait_idle(20 * FRAME, to);
        checks++;
        if (to) begin errors++; $display("FAIL t4_drain_timeout: busy=%b expected 0", tx_busy); end
        hits = 0;
        foreach (rx[i]) if (rx[i] === extra) hits++;
        checks++;
        if (hits != 0) begin errors++; $display("FAIL t4_dropped_byte_sent: got %0d copies expected 0", hits); end
        check_rx_vs_model("t4");
    endtask

    task automatic test_reset_midframe();
        int irq0;
        bit found;
        bit to;
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = 8'($urandom);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_ft == 5 * DIV + 3) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL t5_reach_bit4: got 0 expected 1"); end
        nreset = 1'b0;
        @(posedge clk); #1;
        checks += 4;
        if (uart_out !== 1'b1) begin errors++; $display("FAIL t5_line: got %b expected 1", uart_out); end
        if (fifo_count !== '0) begin errors++; $display("FAIL t5_count: got %0d expected 0", fifo_count); end
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL t5_busy: got %b expected 0", tx_busy); end
        if (tx_done_interrupt !== 1'b0) begin errors++; $display("FAIL t5_irq: got %b expected 0", tx_done_interrupt); end
        nreset = 1'b1;
        irq0 = irq_seen;
        repeat (3 * DIV) @(posedge clk);
        #1;
        checks += 2;
        if (irq_seen != irq0) begin errors++; $display("FAIL t5_no_irq: got %0d pulses expected 0", irq_seen - irq0); end
        if (uart_out !== 1'b1) begin errors++; $display("FAIL t5_idle_line: got %b expected 1", uart_out); end
        rx.delete();
        m_acc.delete();
        b = 8'($urandom);
        wr_en = 1'b1;
        wr_data = b;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_idle(3 * FRAME, to);
        repeat (2) @(posedge clk);
        #1;
        checks += 3;
        if (to) begin errors++; $display("FAIL t5_drain_timeout: busy=%b expected 0", tx_busy); end
        if (irq_seen - irq0 != 1) begin errors++; $display("FAIL t5_irq_after: got %0d expected 1", irq_seen - irq0); end
        if (rx.size() != 1 || rx[0] !== b) begin
            errors++; $display("FAIL t5_clean_frame: got %0d bytes first %h expected 1 byte %h", rx.size(), (rx.size() > 0) ? rx[0] : 8'hxx, b);
        end
    endtask

    task automatic test_push_on_last_stop();
        bit found;
        bit to;
        do_reset();
        wr_en = 1'b1;
        wr_data = 8'($urandom);
        @(posedge clk); #1;
        wr_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_ft == FRAME - 1) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL t6_reach_stop: got 0 expected 1"); end
        wr_en = 1'b1;
        wr_data = 8'($urandom);
        @(posedge clk); #1;
        wr_en = 1'b0;
        checks += 3;
        if (tx_done_interrupt !== 1'b1) begin errors++; $display("FAIL t6_irq: got %b expected 1", tx_done_interrupt); end
        if (uart_out !== 1'b1) begin errors++; $display("FAIL t6_gap_line: got %b expected 1", uart_out); end
        if (fifo_count !== CW'(1)) begin errors++; $display("FAIL t6_count: got %0d expected 1", fifo_count); end
        @(posedge clk); #1;
        checks += 2;
        if (uart_out !== 1'b0) begin errors++; $display("FAIL t6_restart: got %b expected 0", uart_out); end
        if (tx_done_interrupt !== 1'b0) begin errors++; $display("FAIL t6_irq_width: got %b expected 0", tx_done_interrupt); end
        wait_idle(3 * FRAME, to);
        checks++;
        if (to) begin errors++; $display("FAIL t6_drain_timeout: busy=%b expected 0", tx_busy); end
        check_rx_vs_model("t6");
    endtask

    task automatic test_random_traffic();
        bit to;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            wr_en = ($urandom_range(0, 99) < 4);
            wr_data = 8'($urandom);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        wait_idle(20 * FRAME, to);
        checks++;
        if (to) begin errors++; $display("FAIL rnd_drain_timeout: busy=%b expected 0", tx_busy); end
        check_rx_vs_model("rnd");
    endtask

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_push_while_full();
        test_reset_midframe();
        test_push_on_last_stop();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
